// File: rtl/prbs_checker.sv
// PRBS checker: self-synchronising LFSR predictor with hunt/sync/locked
// acquisition, windowed loss-of-lock detection and saturating counters.
module prbs_checker #(
    parameter int LENGTH    = 16,
    parameter int LOCK_CNT  = 32,
    parameter int WINDOW    = 64,
    parameter int LOSS_ERRS = 8,
    parameter int CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [LENGTH-1:0] taps,
    input  logic              din,
    input  logic              din_vld,
    input  logic              clr_cnt,
    output logic              locked,
    output logic              err,
    output logic [CNT_W-1:0]  err_cnt,
    output logic [31:0]       bit_cnt
);

    localparam int FILL_W  = $clog2(LENGTH + 1);
    localparam int MATCH_W = $clog2(LOCK_CNT + 1);
    localparam int WIN_W   = $clog2(WINDOW + 1);
    localparam int WERR_W  = $clog2(LOSS_ERRS + 1);

    typedef enum logic [1:0] {
        ST_HUNT   = 2'd0,
        ST_SYNC   = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    state_t              state_r, state_nxt_s;
    logic [LENGTH-1:0]   lfsr_r, lfsr_nxt_s;
    logic [FILL_W-1:0]   fill_r, fill_nxt_s;
    logic [MATCH_W-1:0]  match_r, match_nxt_s;
    logic [WIN_W-1:0]    win_r, win_nxt_s;
    logic [WERR_W-1:0]   werr_r, werr_nxt_s, werr_sum_s;
    logic [CNT_W-1:0]    err_cnt_r, err_cnt_nxt_s;
    logic [31:0]         bit_cnt_r, bit_cnt_nxt_s;
    logic                err_r, err_nxt_s;
    logic                locked_r;
    logic                pred_s, mism_s;

    // Prediction from the current register contents and the live tap mask.
    always_comb begin
        pred_s = ^(taps & lfsr_r);
        mism_s = din ^ pred_s;
    end

    // Next-state, shift-register and counter update for one valid bit.
    always_comb begin
        state_nxt_s   = state_r;
        lfsr_nxt_s    = lfsr_r;
        fill_nxt_s    = fill_r;
        match_nxt_s   = match_r;
        win_nxt_s     = win_r;
        werr_nxt_s    = werr_r;
        err_cnt_nxt_s = err_cnt_r;
        bit_cnt_nxt_s = bit_cnt_r;
        err_nxt_s     = 1'b0;
        werr_sum_s    = werr_r + WERR_W'(mism_s);
        if (din_vld) begin
            case (state_r)
                ST_HUNT: begin
                    lfsr_nxt_s = {din, lfsr_r[LENGTH-1:1]};
                    if (fill_r == FILL_W'(LENGTH - 1)) begin
                        state_nxt_s = ST_SYNC;
                        fill_nxt_s  = {FILL_W{1'b0}};
                        match_nxt_s = {MATCH_W{1'b0}};
                    end else begin
                        fill_nxt_s = fill_r + 1'b1;
                    end
                end
                ST_SYNC: begin
                    lfsr_nxt_s = {din, lfsr_r[LENGTH-1:1]};
                    if (mism_s) begin
                        match_nxt_s = {MATCH_W{1'b0}};
                    end else if (match_r == MATCH_W'(LOCK_CNT - 1)) begin
                        state_nxt_s = ST_LOCKED;
                        match_nxt_s = {MATCH_W{1'b0}};
                        win_nxt_s   = {WIN_W{1'b0}};
                        werr_nxt_s  = {WERR_W{1'b0}};
                    end else begin
                        match_nxt_s = match_r + 1'b1;
                    end
                end
                ST_LOCKED: begin
                    // Free-running on the prediction so a bad bit does not poison R.
                    lfsr_nxt_s = {pred_s, lfsr_r[LENGTH-1:1]};
                    if (bit_cnt_r != {32{1'b1}}) begin
                        bit_cnt_nxt_s = bit_cnt_r + 32'd1;
                    end else begin
                        bit_cnt_nxt_s = bit_cnt_r;
                    end
                    if (mism_s) begin
                        err_nxt_s = 1'b1;
                        if (err_cnt_r != {CNT_W{1'b1}}) begin
                            err_cnt_nxt_s = err_cnt_r + 1'b1;
                        end else begin
                            err_cnt_nxt_s = err_cnt_r;
                        end
                    end else begin
                        err_nxt_s = 1'b0;
                    end
                    // Loss test precedes the wrap so an error on the last bit still counts.
                    if (werr_sum_s == WERR_W'(LOSS_ERRS)) begin
                        state_nxt_s = ST_HUNT;
                        fill_nxt_s  = {FILL_W{1'b0}};
                        match_nxt_s = {MATCH_W{1'b0}};
                        win_nxt_s   = {WIN_W{1'b0}};
                        werr_nxt_s  = {WERR_W{1'b0}};
                    end else if (win_r == WIN_W'(WINDOW - 1)) begin
                        win_nxt_s  = {WIN_W{1'b0}};
                        werr_nxt_s = {WERR_W{1'b0}};
                    end else begin
                        win_nxt_s  = win_r + 1'b1;
                        werr_nxt_s = werr_sum_s;
                    end
                end
                default: begin
                    state_nxt_s = ST_HUNT;
                end
            endcase
        end else begin
            state_nxt_s = state_r;
        end
        if (clr_cnt) begin
            err_cnt_nxt_s = {CNT_W{1'b0}};
            bit_cnt_nxt_s = 32'd0;
        end else begin
            err_cnt_nxt_s = err_cnt_nxt_s;
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r   <= ST_HUNT;
            lfsr_r    <= {LENGTH{1'b0}};
            fill_r    <= {FILL_W{1'b0}};
            match_r   <= {MATCH_W{1'b0}};
            win_r     <= {WIN_W{1'b0}};
            werr_r    <= {WERR_W{1'b0}};
            err_cnt_r <= {CNT_W{1'b0}};
            bit_cnt_r <= 32'd0;
            err_r     <= 1'b0;
            locked_r  <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            lfsr_r    <= lfsr_nxt_s;
            fill_r    <= fill_nxt_s;
            match_r   <= match_nxt_s;
            win_r     <= win_nxt_s;
            werr_r    <= werr_nxt_s;
            err_cnt_r <= err_cnt_nxt_s;
            bit_cnt_r <= bit_cnt_nxt_s;
            err_r     <= err_nxt_s;
            locked_r  <= (state_nxt_s == ST_LOCKED);
        end
    end

    assign locked  = locked_r;
    assign err     = err_r;
    assign err_cnt = err_cnt_r;
    assign bit_cnt = bit_cnt_r;

endmodule

// File: doc/prbs_checker.md
PRBS_CHECKER -- requirements
Module: prbs_checker

Interface
REQ-001 The block SHALL have parameter LENGTH, default 16, giving the LFSR width matched to the upstream generator.
REQ-002 The block SHALL have parameter LOCK_CNT, default 32, giving the consecutive correct predictions needed to declare lock.
REQ-003 The block SHALL have parameter WINDOW, default 64, giving the loss-of-lock observation window in valid bits.
REQ-004 The block SHALL have parameter LOSS_ERRS, default 8, giving the errors within one WINDOW that drop lock.
REQ-005 The block SHALL have parameter CNT_W, default 16, giving the width of err_cnt.
REQ-006 The block SHALL have port clk, input, 1 bit, the single clock; all logic runs on its rising edge.
REQ-007 The block SHALL have port rst, input, 1 bit, a synchronous active-low reset.
REQ-008 The block SHALL have port taps, input, LENGTH bits, the tap mask, identical to the generator's.
REQ-009 The block SHALL have port din, input, 1 bit, the received bit, equal to the generator's newly inserted MSB (feedback bit).
REQ-010 The block SHALL have port din_vld, input, 1 bit, which qualifies din; cycles with din_vld=0 change no state.
REQ-011 The block SHALL have port clr_cnt, input, 1 bit, which synchronously clears err_cnt and bit_cnt.
REQ-012 The block SHALL have port locked, output, 1 bit, high while in state LOCKED.
REQ-013 The block SHALL have port err, output, 1 bit, a one-cycle pulse on each mismatch counted in LOCKED.
REQ-014 The block SHALL have port err_cnt, output, CNT_W bits, the saturating error count.
REQ-015 The block SHALL have port bit_cnt, output, 32 bits, the saturating count of bits checked in LOCKED.

Function
REQ-016 The block SHALL keep a LENGTH-bit register R with prediction p = XOR-reduce(taps AND R), evaluated combinationally.
REQ-017 On each valid bit, R SHALL update as R <= {b, R[LENGTH-1:1]}, where b = din in HUNT/SYNC and b = p in LOCKED, so a single error does not propagate.
REQ-018 The FSM SHALL have three states: HUNT, SYNC and LOCKED.
REQ-019 HUNT: a fill counter SHALL count valid bits; after LENGTH valid bits the FSM SHALL move to SYNC with the match counter at 0.
REQ-020 SYNC: each valid bit with din==p SHALL increment the match counter, and each valid bit with din!=p SHALL reset it to 0 while the FSM stays in SYNC.
REQ-021 SYNC: when the LOCK_CNT-th consecutive match occurs, the FSM SHALL enter LOCKED on that edge.
REQ-022 LOCKED: each valid bit SHALL increment bit_cnt, which saturates at 2^32-1.
REQ-023 LOCKED: each valid bit with din!=p SHALL pulse err for one cycle (registered, one cycle after the bit) and increment err_cnt, which saturates at all-ones.
REQ-024 LOCKED: a window counter SHALL count valid bits 0..WINDOW-1 and wrap, and a window error counter SHALL count mismatches and clear at the wrap.
REQ-025 LOCKED: when the window error count reaches LOSS_ERRS, the FSM SHALL return to HUNT with the fill, match and window counters cleared; err_cnt and bit_cnt SHALL hold.
REQ-026 When an error lands on the wrap bit, the error SHALL count toward the closing window before the clear.
REQ-027 Errors and counts SHALL NOT be recorded in HUNT or SYNC.
REQ-028 clr_cnt SHALL take priority over a same-cycle increment: the counters become 0, and the concurrent bit is not counted.
REQ-029 A taps change SHALL NOT force a state change; it takes effect as a new prediction polynomial.

Reset
REQ-030 When rst=0 at a clock edge, the block SHALL set R=0, state=HUNT, all internal counters=0, locked=0, err=0, err_cnt=0 and bit_cnt=0.
REQ-031 Reset SHALL take priority over din_vld and clr_cnt, and reset mid-lock SHALL abandon lock immediately.

Verification
REQ-032 The bench SHALL cover: LENGTH=16, taps=16'hB400, continuous valid error-free PRBS -> locked rises exactly LENGTH+LOCK_CNT=48 valid bits after reset release, with err_cnt=0.
REQ-033 The bench SHALL cover: locked, then one din bit flipped -> exactly one err pulse, err_cnt=1, locked stays 1, and following bits produce no errors.
REQ-034 The bench SHALL cover: locked, then 8 flipped bits within one 64-bit window -> locked falls on the 8th error, and relock occurs after a further 48 clean bits.
REQ-035 The bench SHALL cover: din_vld toggled randomly at 50% -> lock and count timing measured in valid bits only, identical to the continuous case.
REQ-036 The bench SHALL cover: err_cnt forced to near all-ones via CNT_W=4 with continuous errors -> err_cnt saturates at 15, and clr_cnt gives 0 on the next cycle.
REQ-037 The bench SHALL cover: rst=0 asserted for one cycle while locked -> on the next edge all outputs are 0, the state is HUNT, and relock occurs after 48 bits.
